// File: rtl/alu_lockstep_ctrl.sv
// Dual-lane lockstep ALU controller: feeds both lanes, compares after ALU_LAT, retries, flags faults.
// Optional macro ALU_LOCKSTEP_INJECT_EN adds inj_i to flip lane-1 operand A bit 0 per request.
module alu_lockstep_ctrl #(
  parameter int ALU_LAT   = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic       op_valid_i,
  output logic       op_ready_o,
  input  logic [3:0] op_a_i,
  input  logic [3:0] op_b_i,
  input  logic [1:0] op_sel_i,
`ifdef ALU_LOCKSTEP_INJECT_EN
  input  logic       inj_i,
`endif
  output logic [3:0] alu_a0_o,
  output logic [3:0] alu_b0_o,
  output logic [3:0] alu_a1_o,
  output logic [3:0] alu_b1_o,
  output logic [1:0] alu_sel1_o,
  output logic [1:0] alu_sel2_o,
  input  logic [3:0] alu_out1_i,
  input  logic       alu_carry1_i,
  input  logic [3:0] cmp_x_i,
  input  logic       cmp_y_i,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic [3:0] res_data_o,
  output logic       res_carry_o,
  output logic       res_err_o,
  output logic       fault_o,
  input  logic       clr_fault_i,
  output logic [7:0] mismatch_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);
  localparam logic [2:0] MAX_R  = 3'(MAX_RETRY);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_wcnt;
  logic [2:0] r_retry;
  logic [3:0] r_a0;
  logic [3:0] r_b0;
  logic [3:0] r_a1;
  logic [3:0] r_b1;
  logic [1:0] r_sel;
  logic [3:0] r_res_data;
  logic       r_res_carry;
  logic       r_res_err;
  logic       r_fault;
  logic [7:0] r_mcnt;

  logic       w_inj;
  logic       w_mismatch;
  logic       w_accept;
  logic       w_retry;
  logic       w_capture;
  logic       w_fail;
  logic       w_clr;

`ifdef ALU_LOCKSTEP_INJECT_EN
  assign w_inj = inj_i;
`else
  assign w_inj = 1'b0;
`endif

  assign w_mismatch = (cmp_x_i != 4'd0) || cmp_y_i;
  assign w_clr      = clr_fault_i && (r_state == IDLE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_retry     = 1'b0;
    w_capture   = 1'b0;
    w_fail      = 1'b0;
    case (r_state)
      IDLE: begin
        if (op_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_wcnt == 3'd0) w_state_nxt = CHECK;
      end
      CHECK: begin
        if (!w_mismatch) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end else if (r_retry < MAX_R) begin
          w_retry     = 1'b1;
          w_state_nxt = WAIT;
        end else begin
          w_capture   = 1'b1;
          w_fail      = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (res_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // WAIT timer and retry bookkeeping
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wcnt  <= 3'd0;
      r_retry <= 3'd0;
    end else begin
      if (w_accept || w_retry)                   r_wcnt <= LAT_M1;
      else if (r_state == WAIT && r_wcnt != 3'd0) r_wcnt <= r_wcnt - 3'd1;
      if (w_accept)     r_retry <= 3'd0;
      else if (w_retry) r_retry <= r_retry + 3'd1;
    end
  end

  // Lane operands are loaded only on accept so retries replay the same request
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_a0  <= 4'd0;
      r_b0  <= 4'd0;
      r_a1  <= 4'd0;
      r_b1  <= 4'd0;
      r_sel <= 2'd0;
    end else if (w_accept) begin
      r_a0  <= op_a_i;
      r_b0  <= op_b_i;
      r_a1  <= op_a_i ^ {3'd0, w_inj};
      r_b1  <= op_b_i;
      r_sel <= op_sel_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_res_data  <= 4'd0;
      r_res_carry <= 1'b0;
      r_res_err   <= 1'b0;
    end else if (w_capture) begin
      r_res_data  <= alu_out1_i;
      r_res_carry <= alu_carry1_i;
      r_res_err   <= w_fail;
    end
  end

  // Clear is only honoured in IDLE, where neither set nor count can happen
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_fault <= 1'b0;
      r_mcnt  <= 8'd0;
    end else if (w_clr) begin
      r_fault <= 1'b0;
      r_mcnt  <= 8'd0;
    end else begin
      if (w_fail) r_fault <= 1'b1;
      if (r_state == CHECK && w_mismatch) r_mcnt <= sat_inc(r_mcnt);
    end
  end

  assign op_ready_o     = (r_state == IDLE);
  assign res_valid_o    = (r_state == RESP);
  assign alu_a0_o       = r_a0;
  assign alu_b0_o       = r_b0;
  assign alu_a1_o       = r_a1;
  assign alu_b1_o       = r_b1;
  assign alu_sel1_o     = r_sel;
  assign alu_sel2_o     = r_sel;
  assign res_data_o     = r_res_data;
  assign res_carry_o    = r_res_carry;
  assign res_err_o      = r_res_err;
  assign fault_o        = r_fault;
  assign mismatch_cnt_o = r_mcnt;

endmodule

// File: doc/alu_lockstep_ctrl.md
ALU_LOCKSTEP_CTRL -- requirements
Module: alu_lockstep_ctrl

Interface
REQ-001 Parameter ALU_LAT, default 1, clock cycles from operand change to valid ALU outputs (1..7).
REQ-002 Parameter MAX_RETRY, default 2, re-checks allowed after a lane mismatch before a fault is declared (0..7).
REQ-003 wb_clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 wb_rst_ni  in  1  asynchronous, active-low reset.
REQ-005 op_valid_i  in  1  request valid.
REQ-006 op_ready_o  out  1  controller can accept a request.
REQ-007 op_a_i, op_b_i  in  4 each  operands.
REQ-008 op_sel_i  in  2  ALU select, passed through opaquely.
REQ-009 alu_a0_o, alu_b0_o, alu_a1_o, alu_b1_o  out  4 each  lane operands.
REQ-010 alu_sel1_o, alu_sel2_o  out  2 each  lane selects.
REQ-011 alu_out1_i  in  4  lane-1 result; alu_carry1_i  in  1  lane-1 carry.
REQ-012 cmp_x_i  in  4  lane result XOR; cmp_y_i  in  1  carry mismatch.
REQ-013 res_valid_o  out  1; res_ready_i  in  1  result handshake.
REQ-014 res_data_o  out  4; res_carry_o  out  1; res_err_o  out  1  result payload.
REQ-015 fault_o  out  1  sticky lockstep fault.
REQ-016 clr_fault_i  in  1  fault clear pulse.
REQ-017 mismatch_cnt_o  out  8  mismatch counter.

Function
REQ-018 States: IDLE, WAIT, CHECK, RESP; op_ready_o=1 only in IDLE.
REQ-019 Accept = op_valid_i&&op_ready_o; registers op_a/op_b/op_sel into both lanes identically, clears retry count, enters WAIT.
REQ-020 Lane outputs hold their registered values outside the accept edge.
REQ-021 WAIT lasts exactly ALU_LAT cycles, then CHECK.
REQ-022 CHECK samples inputs for one cycle; mismatch = (cmp_x_i!=0)||cmp_y_i.
REQ-023 CHECK, no mismatch: capture alu_out1_i/alu_carry1_i, res_err_o=0, enter RESP.
REQ-024 CHECK, mismatch, retries<MAX_RETRY: increment retries, re-enter WAIT (operands unchanged).
REQ-025 CHECK, mismatch, retries==MAX_RETRY: capture lane-1 values, res_err_o=1, set fault_o, enter RESP.
REQ-026 Every CHECK mismatch increments mismatch_cnt_o, saturating at 255.
REQ-027 res_valid_o=1 exactly in RESP; payload stable until res_valid_o&&res_ready_i, then IDLE.
REQ-028 Fault-free latency accept-edge to res_valid_o = ALU_LAT+2 cycles.
REQ-029 Requests are accepted regardless of fault_o.
REQ-030 clr_fault_i clears fault_o and mismatch_cnt_o only in IDLE; ignored elsewhere.
REQ-031 If fault set and clr_fault_i coincide in IDLE, clear wins (set cannot occur in IDLE).

Reset
REQ-032 Reset asserted forces IDLE immediately, regardless of state, including mid-WAIT/RESP.
REQ-033 Reset values: all lane outputs 0, res_valid_o=0, res_data_o=0, res_carry_o=0, res_err_o=0, fault_o=0, mismatch_cnt_o=0, op_ready_o=1.
REQ-034 An in-flight request at reset is dropped; no response produced.

Configuration
REQ-035 Macro ALU_LOCKSTEP_INJECT_EN defined: extra input inj_i (1 bit); when high at accept, alu_a1_o bit 0 is inverted for that request, all retries included.
REQ-036 Macro undefined: no inj_i port; lanes always receive identical operands.

Verification
REQ-037 ALU_LAT=1, accept a=4'h3,b=4'h5, cmp inputs 0, alu_out1_i=4'h8 -> res_valid_o at cycle 3, res_data_o=4'h8, res_err_o=0, mismatch_cnt_o=0.
REQ-038 MAX_RETRY=2, cmp_x_i=4'h1 on first CHECK then 0 -> one retry, res_err_o=0, mismatch_cnt_o=1, fault_o=0, latency ALU_LAT+2+ALU_LAT+1.
REQ-039 cmp_y_i=1 held -> 3 CHECKs, res_err_o=1, fault_o=1, mismatch_cnt_o=3; clr_fault_i in IDLE -> both 0.
REQ-040 res_ready_i low 5 cycles in RESP -> res_valid_o and payload stable, op_ready_o=0 throughout.
REQ-041 wb_rst_ni low during WAIT -> outputs at reset values same cycle, no response after release.
REQ-042 ALU_LOCKSTEP_INJECT_EN, inj_i=1, a=4'h6 -> alu_a0_o=4'h6, alu_a1_o=4'h7 on every retry.
